// File: rtl/input_format_expander_pkg.sv
// Shared fixed-point constants and types for the input formatter and the
// output rounding/saturation stage.
package input_format_expander_pkg;

    localparam int IN_WIDTH_DEF    = 16;
    localparam int IN_FRAC_DEF     = 15;
    localparam int ACC_WIDTH_DEF   = 42;
    localparam int ACC_FRAC_DEF    = 32;
    localparam int SHIFT_WIDTH_DEF = 4;
    localparam int CNT_WIDTH_DEF   = 16;

    // Alignment shift between the input and accumulator fractional formats.
    localparam int FRAC_DIFF = ACC_FRAC_DEF - IN_FRAC_DEF;

    typedef struct packed {
        logic pos;
        logic neg;
    } sat_flags_t;

    // Accumulator MAX / MIN for a w-bit two's-complement word.
    // Callers size the result down to w bits.
    function automatic logic [127:0] acc_max(input int w);
        acc_max = (128'(1) << (w - 1)) - 128'(1);
    endfunction

    function automatic logic [127:0] acc_min(input int w);
        acc_min = 128'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/input_format_expander_shift_saturate.sv
// Combinational align-and-clip: sample <<< (base + shift), widened enough that
// no bit is lost before the range check, then clipped to the accumulator range.
module shift_saturate
    import input_format_expander_pkg::*;
#(
    parameter int IN_WIDTH    = IN_WIDTH_DEF,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
    parameter int SHIFT_BASE  = FRAC_DIFF
) (
    input  logic signed [IN_WIDTH-1:0]    sample_i,
    input  logic        [SHIFT_WIDTH-1:0] shift_i,
    output logic        [ACC_WIDTH-1:0]   value_o,
    output sat_flags_t                    flags_o
);

    // Wide enough for any alignment shift below ACC_WIDTH plus the full gain range.
    localparam int EXT_WIDTH = ACC_WIDTH + IN_WIDTH + 2**SHIFT_WIDTH;

    localparam logic [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'(acc_max(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(acc_min(ACC_WIDTH));

    logic signed [EXT_WIDTH-1:0]         ext;
    logic signed [EXT_WIDTH-1:0]         shifted;
    logic        [EXT_WIDTH-ACC_WIDTH:0] upper;

    always_comb begin
        ext     = EXT_WIDTH'(sample_i);
        shifted = ext <<< (SHIFT_BASE + int'(shift_i));
        // Fits iff every bit from the result sign down to the accumulator sign agrees.
        upper   = shifted[EXT_WIDTH-1:ACC_WIDTH-1];

        flags_o.pos = !shifted[EXT_WIDTH-1] && (|upper);
        flags_o.neg =  shifted[EXT_WIDTH-1] && !(&upper);

        if (flags_o.pos) begin
            value_o = MAX_V;
        end else if (flags_o.neg) begin
            value_o = MIN_V;
        end else begin
            value_o = shifted[ACC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/input_format_expander.sv
// Two-stage elastic front end: registers the raw sample, aligns/clips it, and
// keeps sticky saturation statistics counted on the output handshake.
module input_format_expander
    import input_format_expander_pkg::*;
#(
    parameter int IN_WIDTH    = IN_WIDTH_DEF,
    parameter int IN_FRAC     = IN_FRAC_DEF,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int ACC_FRAC    = IN_FRAC_DEF + FRAC_DIFF,
    parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IN_WIDTH-1:0]    data_in,
    input  logic [SHIFT_WIDTH-1:0] gain_shift,
    input  logic                   valid_in,
    output logic                   ready_out,
    output logic [ACC_WIDTH-1:0]   data_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic                   sat_pos,
    output logic                   sat_neg,
    output logic                   sat_sticky,
    output logic [CNT_WIDTH-1:0]   sat_count,
    input  logic                   clr_stats
);

    localparam int SHIFT_BASE = ACC_FRAC - IN_FRAC;

    logic                          v1_q, v1_d;
    logic signed [IN_WIDTH-1:0]    d1_q, d1_d;
    logic        [SHIFT_WIDTH-1:0] s1_q, s1_d;

    logic                          v2_q, v2_d;
    logic        [ACC_WIDTH-1:0]   dout_q, dout_d;
    sat_flags_t                    flags_q, flags_d;

    logic                          sticky_q, sticky_d;
    logic        [CNT_WIDTH-1:0]   count_q, count_d;

    logic                          adv1, adv2, out_hs, sat_hit;
    logic        [ACC_WIDTH-1:0]   ss_value;
    sat_flags_t                    ss_flags;

    shift_saturate #(
        .IN_WIDTH    (IN_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH),
        .SHIFT_BASE  (SHIFT_BASE)
    ) u_shift_saturate (
        .sample_i (d1_q),
        .shift_i  (s1_q),
        .value_o  (ss_value),
        .flags_o  (ss_flags)
    );

    always_comb begin
        adv2 = !v2_q || ready_in;
        adv1 = !v1_q || adv2;

        v1_d = v1_q;
        d1_d = d1_q;
        s1_d = s1_q;
        if (adv1) begin
            v1_d = valid_in;
            if (valid_in) begin
                d1_d = $signed(data_in);
                s1_d = gain_shift;
            end
        end

        // Payload and flags only change when a real sample lands, so a
        // stalled output stays bit-stable.
        v2_d    = v2_q;
        dout_d  = dout_q;
        flags_d = flags_q;
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                dout_d  = ss_value;
                flags_d = ss_flags;
            end
        end

        out_hs   = v2_q && ready_in;
        sat_hit  = out_hs && (flags_q.pos || flags_q.neg);
        sticky_d = sticky_q;
        count_d  = count_q;
        if (clr_stats) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end else if (sat_hit) begin
            sticky_d = 1'b1;
            if (count_q != {CNT_WIDTH{1'b1}}) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            d1_q     <= '0;
            s1_q     <= '0;
            v2_q     <= 1'b0;
            dout_q   <= '0;
            flags_q  <= '0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            v1_q     <= v1_d;
            d1_q     <= d1_d;
            s1_q     <= s1_d;
            v2_q     <= v2_d;
            dout_q   <= dout_d;
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign ready_out  = adv1;
    assign valid_out  = v2_q;
    assign data_out   = dout_q;
    assign sat_pos    = flags_q.pos;
    assign sat_neg    = flags_q.neg;
    assign sat_sticky = sticky_q;
    assign sat_count  = count_q;

endmodule

// File: tb/tb_input_format_expander.sv
// Bench for input_format_expander: arithmetic reference model with a per-cycle
// scoreboard, plus directed vectors with literal expectations.
module tb_input_format_expander;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic [3:0]  gain_shift;
    logic        valid_in;
    logic        ready_out;
    logic [41:0] data_out;
    logic        valid_out;
    logic        ready_in;
    logic        sat_pos;
    logic        sat_neg;
    logic        sat_sticky;
    logic [15:0] sat_count;
    logic        clr_stats;

    always #5 clk = ~clk;

    input_format_expander dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .gain_shift (gain_shift),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .sat_pos    (sat_pos),
        .sat_neg    (sat_neg),
        .sat_sticky (sat_sticky),
        .sat_count  (sat_count),
        .clr_stats  (clr_stats)
    );

    typedef struct {
        logic [41:0] v;
        bit          p;
        bit          n;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          m_cnt = 0;
    bit          m_sticky = 0;
    bit          prev_stall = 0;
    logic [41:0] prev_data;
    logic        prev_p, prev_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // value = data * 2^(17+shift), clipped to the signed 42-bit range
    function automatic exp_t model(input logic [15:0] d, input logic [3:0] s);
        exp_t   e;
        longint x, mx, mn;
        x   = longint'($signed(d)) * (longint'(1) << (17 + int'(s)));
        mx  = (longint'(1) << 41) - 1;
        mn  = -(longint'(1) << 41);
        e.p = x > mx;
        e.n = x < mn;
        if (e.p) x = mx;
        else if (e.n) x = mn;
        e.v = x[41:0];
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_cnt      = 0;
            m_sticky   = 0;
            prev_stall = 0;
        end else begin
            exp_t e;
            chk("sat_count", 64'(sat_count), 64'(m_cnt));
            chk("sat_sticky", 64'(sat_sticky), 64'(m_sticky));
            chk("ready_out", 64'(ready_out), 64'(!(q.size() == 2 && !ready_in)));
            if (prev_stall) begin
                chk("stall_valid", 64'(valid_out), 64'(1));
                chk("stall_data", 64'(data_out), 64'(prev_data));
                chk("stall_flags", {62'(0), sat_pos, sat_neg}, {62'(0), prev_p, prev_n});
            end
            if (valid_out && ready_in) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'(1), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("data_out", 64'(data_out), 64'(e.v));
                    chk("sat_pos", 64'(sat_pos), 64'(e.p));
                    chk("sat_neg", 64'(sat_neg), 64'(e.n));
                    if (!clr_stats && (e.p || e.n)) begin
                        m_sticky = 1;
                        if (m_cnt < 65535) m_cnt++;
                    end
                end
            end
            if (clr_stats) begin
                m_cnt    = 0;
                m_sticky = 0;
            end
            if (valid_in && ready_out) q.push_back(model(data_in, gain_shift));
            prev_stall = valid_out && !ready_in;
            prev_data  = data_out;
            prev_p     = sat_pos;
            prev_n     = sat_neg;
        end
    end

    task automatic push(input logic [15:0] d, input logic [3:0] s);
        bit ok;
        @(posedge clk);
        #1;
        data_in    = d;
        gain_shift = s;
        valid_in   = 1'b1;
        ok = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (ready_out) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 64'(ok), 64'(1));
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (valid_out) begin
                lat = i;
                return;
            end
        end
    endtask

    logic [15:0] tv_d[8] = '{16'h4000, 16'hC000, 16'h7FFF, 16'h8000,
                             16'h1234, 16'hFFFF, 16'h0001, 16'h8000};
    logic [3:0]  tv_s[8] = '{4'd0, 4'd2, 4'd15, 4'd15, 4'd5, 4'd0, 4'd15, 4'd9};
    logic [31:0] rdy_pat = 32'b1011_0010_1110_0100_1101_0001_0111_0011;

    initial begin
        int lat;
        rst        = 1'b0;
        valid_in   = 1'b0;
        ready_in   = 1'b1;
        clr_stats  = 1'b0;
        data_in    = '0;
        gain_shift = '0;
        #2 rst = 1'b1;
        #6;
        chk("reset_valid_out", 64'(valid_out), 64'(0));
        chk("reset_data_out", 64'(data_out), 64'(0));
        chk("reset_ready_out", 64'(ready_out), 64'(1));
        chk("reset_sat_count", 64'(sat_count), 64'(0));
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // 0.5 aligned: 0x000_8000_0000
        push(16'h4000, 4'd0);
        wait_out(lat);
        chk("latency", 64'(lat), 64'(2));
        chk("t1_data", 64'(data_out), 64'h000_8000_0000);
        chk("t1_flags", {62'(0), sat_pos, sat_neg}, 64'(0));

        push(16'h4000, 4'd3);
        wait_out(lat);
        chk("t2_data", 64'(data_out), 64'h004_0000_0000);
        chk("t2_flags", {62'(0), sat_pos, sat_neg}, 64'(0));

        push(16'h4000, 4'd10);
        wait_out(lat);
        chk("t3_data", 64'(data_out), 64'h1FF_FFFF_FFFF);
        chk("t3_sat_pos", 64'(sat_pos), 64'(1));
        @(negedge clk);
        chk("t3_count", 64'(sat_count), 64'(1));

        push(16'h8000, 4'd10);
        wait_out(lat);
        chk("t4_data", 64'(data_out), 64'h200_0000_0000);
        chk("t4_sat_neg", 64'(sat_neg), 64'(1));
        @(negedge clk);
        chk("t4_count", 64'(sat_count), 64'(2));
        chk("t4_sticky", 64'(sat_sticky), 64'(1));

        // exact MIN is not saturation
        push(16'h8000, 4'd9);
        wait_out(lat);
        chk("t5_data", 64'(data_out), 64'h200_0000_0000);
        chk("t5_flags", {62'(0), sat_pos, sat_neg}, 64'(0));
        @(negedge clk);
        chk("t5_count", 64'(sat_count), 64'(2));

        // clear coincident with a saturating output handshake
        push(16'h4000, 4'd10);
        @(posedge clk);
        #1 clr_stats = 1'b1;
        @(negedge clk);
        chk("clr_hs_valid", 64'(valid_out && ready_in && sat_pos), 64'(1));
        @(posedge clk);
        #1 clr_stats = 1'b0;
        chk("clr_count", 64'(sat_count), 64'(0));
        chk("clr_sticky", 64'(sat_sticky), 64'(0));

        // back-to-back stream with downstream backpressure
        fork
            begin
                bit ok;
                @(posedge clk);
                #1;
                for (int i = 0; i < 8; i++) begin
                    data_in    = tv_d[i];
                    gain_shift = tv_s[i];
                    valid_in   = 1'b1;
                    ok = 0;
                    for (int t = 0; t < 40; t++) begin
                        @(negedge clk);
                        if (ready_out) begin
                            ok = 1;
                            break;
                        end
                    end
                    chk("stream_accept", 64'(ok), 64'(1));
                    @(posedge clk);
                    #1;
                end
                valid_in = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    @(posedge clk);
                    #1 ready_in = rdy_pat[c % 32];
                end
                ready_in = 1'b1;
            end
        join
        for (int t = 0; t < 50 && q.size() != 0; t++) @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'(0));

        // fill both stages, then reset mid-stream
        @(posedge clk);
        #1 ready_in = 1'b0;
        push(16'h4000, 4'd10);
        push(16'h0100, 4'd1);
        @(negedge clk);
        chk("full_ready_out", 64'(ready_out), 64'(0));
        chk("full_valid_out", 64'(valid_out), 64'(1));
        chk("full_sat_pos", 64'(sat_pos), 64'(1));
        chk("pre_reset_count_nz", 64'(sat_count != 0), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_valid_out", 64'(valid_out), 64'(0));
        chk("rst_data_out", 64'(data_out), 64'(0));
        chk("rst_sat_pos", 64'(sat_pos), 64'(0));
        chk("rst_sat_count", 64'(sat_count), 64'(0));
        chk("rst_sat_sticky", 64'(sat_sticky), 64'(0));
        chk("rst_ready_out", 64'(ready_out), 64'(1));
        @(negedge clk);
        #2 rst = 1'b0;
        ready_in = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 64'(valid_out), 64'(0));

        push(16'hC000, 4'd3);
        wait_out(lat);
        chk("post_rst_latency", 64'(lat), 64'(2));
        chk("post_rst_data", 64'(data_out), 64'h3FC_0000_0000);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
